// File: rtl/approx_seq_mul.sv
// Purpose : sequential shift-add approximate unsigned multiplier. Each partial
//           product has its low TRUNC_BITS columns forced to zero.
// Latency : out_valid rises WIDTH edges after the accepting edge. One result
//           per WIDTH+2 cycles when out_ready is held high.
// Backpr. : in_ready is high only in IDLE, and operands are not queued. The
//           result is held in DONE until out_ready is sampled high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair valid           in_ready  accepts operands (IDLE only)
//   in_a       multiplicand, WIDTH bits     in_b      multiplier, WIDTH bits
//   out_valid  out_p valid (DONE)           out_ready consumer accepts out_p
//   out_p      approximate product, 2*WIDTH bits
//   busy       high while in RUN or DONE
//
// Optional feature: define APPROX_MUL_BIAS_COMP_EN to add a rounding bias of
// 2^(TRUNC_BITS-1) to every result on the RUN->DONE transition. The biased
// result saturates at 2^(2*WIDTH)-1. The bias adds no latency and is not
// applied when TRUNC_BITS is 0.

module approx_seq_mul #(
    parameter int WIDTH      = 4,
    parameter int TRUNC_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Column mask applied to every partial product. Columns below TRUNC_BITS
    // are never summed.
    localparam logic [PW-1:0]    PP_MASK  = {PW{1'b1}} << TRUNC_BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef APPROX_MUL_BIAS_COMP_EN
    // Half of the weight of the lowest kept column. This recentres the
    // truncation error. The value is zero when nothing is truncated.
    localparam int            BIAS_SH = (TRUNC_BITS > 0) ? (TRUNC_BITS - 1) : 0;
    localparam logic [PW:0]   BIAS    = (TRUNC_BITS > 0) ? ((PW + 1)'(1) << BIAS_SH)
                                                         : '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [PW-1:0]      acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      out_p_q;
    logic               out_valid_q;

    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      pp_d;
    logic [PW-1:0]      acc_d;
    logic [PW-1:0]      result_d;

    // ------------------------------------------------------------------
    // Datapath: one partial product per RUN cycle.
    // ------------------------------------------------------------------
    assign a_ext = {{WIDTH{1'b0}}, a_q};
    assign pp_d  = (a_ext << cnt_q) & PP_MASK;

    // Without a bias the truncated sum never exceeds the exact product.
    // The accumulator therefore cannot overflow 2*WIDTH bits.
    assign acc_d = b_q[cnt_q] ? (acc_q + pp_d) : acc_q;

`ifdef APPROX_MUL_BIAS_COMP_EN
    logic [PW:0] biased_sum;

    // One extra bit catches the carry out of the bias add. Saturate on carry.
    assign biased_sum = {1'b0, acc_d} + BIAS;
    assign result_d   = biased_sum[PW] ? {PW{1'b1}} : biased_sum[PW-1:0];
`else
    assign result_d   = acc_d;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered result and out_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Always run all WIDTH steps, even for zero operands.
                    // This keeps the latency fixed.
                    if (cnt_q == CNT_LAST) begin
                        out_p_q     <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;

endmodule

// File: tb/tb_approx_seq_mul.sv
// Self-checking bench for approx_seq_mul.
// The bench uses two instances with WIDTH=4: one with TRUNC_BITS=2 and one
// exact instance with TRUNC_BITS=0. Both share the same stimulus.

module tb_approx_seq_mul;

    localparam int W    = 4;
    localparam int T    = 2;
    localparam int PMAX = (1 << (2 * W)) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;

    logic           in_ready, out_valid, busy;
    logic [2*W-1:0] out_p;
    logic           ex_in_ready, ex_out_valid, ex_busy;
    logic [2*W-1:0] ex_out_p;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    approx_seq_mul #(.WIDTH(W), .TRUNC_BITS(T)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    approx_seq_mul #(.WIDTH(W), .TRUNC_BITS(0)) u_exact (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ex_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (ex_out_valid),
        .out_ready (out_ready),
        .out_p     (ex_out_p),
        .busy      (ex_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truncated-product reference. Sum the set-bit partial products of a,
    // with each partial product's low t columns cleared. An optional
    // compensation bias is added, and the result saturates.
    function automatic int golden(input int a, input int b, input int t);
        int s;
        s = 0;
        for (int i = 0; i < W; i++)
            if (((b >> i) & 1) == 1)
                s += ((a << i) >> t) << t;
`ifdef APPROX_MUL_BIAS_COMP_EN
        if (t > 0) s += 1 << (t - 1);
        if (s > PMAX) s = PMAX;
`endif
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural timing model. An accepted op becomes visible W edges
    // later. The model then holds the result until a handshake.
    // ------------------------------------------------------------------
    int   m_phase = 0;     // 0 idle, 1 computing, 2 presenting
    int   m_left  = 0;
    int   m_ops   = 0;
    int   m_pend = 0, m_pend_ex = 0;
    int   m_p = 0, m_p_ex = 0;
    bit   m_v = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_v     = 1'b0;
            m_p     = 0;
            m_p_ex  = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend    = golden(int'(in_a), int'(in_b), T);
                    m_pend_ex = int'(in_a) * int'(in_b);
                    m_left    = W;
                    m_phase   = 1;
                    m_ops++;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_v     = 1'b1;
                        m_p     = m_pend;
                        m_p_ex  = m_pend_ex;
                    end
                end
                default: if (out_ready) begin
                    m_phase = 0;
                    m_v     = 1'b0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("out_valid",    32'(out_valid),    32'(m_v));
        chk("out_p",        32'(out_p),        32'(m_p));
        chk("in_ready",     32'(in_ready),     32'(m_phase == 0));
        chk("busy",         32'(busy),         32'(m_phase != 0));
        chk("ex_out_valid", 32'(ex_out_valid), 32'(m_v));
        chk("ex_out_p",     32'(ex_out_p),     32'(m_p_ex));
        chk("ex_in_ready",  32'(ex_in_ready),  32'(m_phase == 0));
    end

    // Advance one cycle. Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait, bounded, until the next edge will accept operands.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, " ready_wait"}, 32'(in_ready), 32'd1);
    endtask

    // Run one directed operation and check the pinned literal results.
    // Hold out_ready low for 'hold' cycles in DONE, with in_valid noise.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_p, input int exp_ex, input int hold,
                          input string tag);
        int n;
        out_ready = 1'b0;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        wait_ready(tag);
        step();                       // accepting edge
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(W));
        chk({tag, " out_p"}, 32'(out_p), 32'(exp_p));
        chk({tag, " exact out_p"}, 32'(ex_out_p), 32'(exp_ex));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            step();
            chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold out_p"}, 32'(out_p), 32'(exp_p));
            chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();                       // handshake edge
        chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    int exp_32, exp_1515, exp_09, exp_23;
    int acc_cyc[3];
    int target;
    int budget;

    initial begin
`ifdef APPROX_MUL_BIAS_COMP_EN
        exp_32 = 6; exp_1515 = 222; exp_09 = 2; exp_23 = 6;
`else
        exp_32 = 4; exp_1515 = 220; exp_09 = 0; exp_23 = 4;
`endif
        // Reset state, checked before any clock edge.
        #1;
        chk("reset out_p",     32'(out_p),     32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset busy",      32'(busy),      32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        run_op(4'd3,  4'd2,  exp_32,   6,   0, "a3b2");
        run_op(4'd15, 4'd15, exp_1515, 225, 5, "a15b15_bp");
        run_op(4'd0,  4'd9,  exp_09,   0,   0, "a0b9");

        // Back-to-back ops with out_ready high. Accepts must be 6 cycles apart.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_a     = (k == 0) ? 4'd3 : (k == 1) ? 4'd15 : 4'd5;
            in_b     = (k == 0) ? 4'd2 : (k == 1) ? 4'd15 : 4'd7;
            in_valid = 1'b1;
            wait_ready("b2b");
            acc_cyc[k] = cyc;
            step();
        end
        in_valid = 1'b0;
        chk("b2b spacing 1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
        chk("b2b spacing 2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
        repeat (W + 3) step();

        // Assert reset asynchronously in the second RUN cycle of 7*5.
        in_a = 4'd7; in_b = 4'd5; in_valid = 1'b1;
        wait_ready("rst_mid");
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("async rst in_ready",  32'(in_ready),  32'd1);
        chk("async rst busy",      32'(busy),      32'd0);
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_p",     32'(out_p),     32'd0);
        step();
        rst = 1'b0;
        repeat (W + 3) step();        // no out_valid may appear here
        run_op(4'd2, 4'd3, exp_23, 6, 0, "a2b3_after_rst");

        // Randomized traffic with random backpressure.
        target = m_ops + 1000;
        budget = 0;
        while (m_ops < target && budget < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       in_a = 4'd0;
                1:       in_a = 4'd15;
                default: in_a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       in_b = 4'd0;
                1:       in_b = 4'd15;
                default: in_b = W'($urandom);
            endcase
            step();
            budget++;
        end
        chk("random op count reached", 32'(m_ops >= target), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
